// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable prescaler, horizontal/vertical
// counters, registered sync/blanking outputs and line/frame boundary strobes.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned CW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          p_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_end,
    output logic          frame_end
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_DISP   = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_DISP   = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;
    logic          hs_next;
    logic          vs_next;
    logic          vo_next;

    // Strobes decode straight from the current counters so they coincide with p_tick
    always_comb begin
        p_tick    = enable && (div == DIV_LAST);
        line_end  = p_tick && (pixel_x == H_LAST);
        frame_end = line_end && (pixel_y == V_LAST);
    end

    // Next-state counters and the sync/blank decode of that next position, so the
    // registered outputs always describe the coordinates shown in the same cycle
    always_comb begin
        div_next = '0;
        x_next   = '0;
        y_next   = '0;
        hs_next  = ~HS_POL;
        vs_next  = ~VS_POL;
        vo_next  = 1'b0;
        if (enable) begin
            div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
            x_next   = pixel_x;
            y_next   = pixel_y;
            if (p_tick) begin
                if (pixel_x == H_LAST) begin
                    x_next = '0;
                    y_next = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
                end else begin
                    x_next = pixel_x + 1'b1;
                end
            end
            hs_next = ((x_next >= HS_FIRST) && (x_next <= HS_LAST)) ? HS_POL : ~HS_POL;
            vs_next = ((y_next >= VS_FIRST) && (y_next <= VS_LAST)) ? VS_POL : ~VS_POL;
            vo_next = (x_next < H_DISP) && (y_next < V_DISP);
        end
    end

    // State registers; enable=0 loads the same values as reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            pixel_x  <= '0;
            pixel_y  <= '0;
            hsync    <= ~HS_POL;
            vsync    <= ~VS_POL;
            video_on <= 1'b0;
        end else begin
            div      <= div_next;
            pixel_x  <= x_next;
            pixel_y  <= y_next;
            hsync    <= hs_next;
            vsync    <= vs_next;
            video_on <= vo_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480/div-4 instance and a tiny
// CLK_DIV=1, positive-polarity instance share clock, reset and enable.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;

    logic       d_pt, d_hs, d_vs, d_vo, d_le, d_fe;
    logic [9:0] d_x, d_y;
    logic       s_pt, s_hs, s_vs, s_vo, s_le, s_fe;
    logic [9:0] s_x, s_y;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .enable(enable),
        .p_tick(d_pt), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
        .pixel_x(d_x), .pixel_y(d_y), .line_end(d_le), .frame_end(d_fe)
    );

    vga_timing_gen #(
        .CLK_DIV(1),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
    ) u_small (
        .clk(clk), .reset(reset), .enable(enable),
        .p_tick(s_pt), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
        .pixel_x(s_x), .pixel_y(s_y), .line_end(s_le), .frame_end(s_fe)
    );

    typedef enum logic [2:0] {S_PT, S_X, S_Y, S_HS, S_VS, S_VO, S_LE, S_FE} sig_e;

    typedef struct {
        int unsigned n;     // edges since release with enable=1
        bit          inst;  // 0 = default instance, 1 = small instance
        sig_e        sig;
        int unsigned exp;
    } vec_t;

    vec_t        vecs[$];
    int          tests = 0;
    int          failed = 0;
    int unsigned cur_n = 0;

    function automatic int unsigned get(bit inst, sig_e s);
        if (!inst) begin
            case (s)
                S_PT: return int'(d_pt);
                S_X:  return int'(d_x);
                S_Y:  return int'(d_y);
                S_HS: return int'(d_hs);
                S_VS: return int'(d_vs);
                S_VO: return int'(d_vo);
                S_LE: return int'(d_le);
                default: return int'(d_fe);
            endcase
        end else begin
            case (s)
                S_PT: return int'(s_pt);
                S_X:  return int'(s_x);
                S_Y:  return int'(s_y);
                S_HS: return int'(s_hs);
                S_VS: return int'(s_vs);
                S_VO: return int'(s_vo);
                S_LE: return int'(s_le);
                default: return int'(s_fe);
            endcase
        end
    endfunction

    function automatic void add(int unsigned n, bit inst, sig_e s, int unsigned e);
        vec_t v;
        v.n = n; v.inst = inst; v.sig = s; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, bit inst, sig_e s, int unsigned e);
        int unsigned a;
        a = get(inst, s);
        tests++;
        if (a != e) begin
            failed++;
            $display("FAIL %s inst=%0d sig=%s n=%0d: got %0d expected %0d",
                     name, inst, s.name(), cur_n, a, e);
        end
    endtask

    // one clock edge, then settle to posedge+2 where inputs are driven and outputs sampled
    task automatic tick();
        @(posedge clk);
        #2;
        cur_n++;
    endtask

    task automatic advance(int unsigned n);
        while (cur_n < n) tick();
    endtask

    // reset, then release with enable=1 at posedge+2 (n=0)
    task automatic reset_and_start();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b0;
        enable = 1'b1;
        cur_n  = 0;
        #1;
    endtask

    initial begin
        // default instance: reset state, prescaler latency, segment edges, line wrap
        add(0, 0, S_X, 0);   add(0, 0, S_Y, 0);   add(0, 0, S_VO, 0);
        add(0, 0, S_HS, 1);  add(0, 0, S_VS, 1);  add(0, 0, S_PT, 0);
        add(0, 0, S_LE, 0);
        // small instance: reset state with p_tick already high (CLK_DIV=1)
        add(0, 1, S_X, 0);   add(0, 1, S_VO, 0);  add(0, 1, S_HS, 0);
        add(0, 1, S_VS, 0);  add(0, 1, S_PT, 1);
        add(1, 0, S_X, 0);   add(1, 0, S_VO, 1);  add(1, 0, S_PT, 0);
        add(1, 1, S_X, 1);   add(1, 1, S_VO, 1);
        add(3, 0, S_PT, 1);  add(3, 0, S_X, 0);
        add(4, 0, S_X, 1);   add(4, 0, S_PT, 0);
        add(7, 1, S_X, 7);   add(7, 1, S_VO, 1);
        add(8, 1, S_X, 8);   add(8, 1, S_VO, 0);
        add(9, 1, S_HS, 0);
        add(10, 1, S_HS, 1); add(11, 1, S_HS, 1); add(12, 1, S_HS, 0);
        add(13, 1, S_X, 13); add(13, 1, S_LE, 1); add(13, 1, S_FE, 0);
        add(14, 1, S_X, 0);  add(14, 1, S_Y, 1);  add(14, 1, S_VO, 1);
        add(14, 1, S_LE, 0);
        add(56, 1, S_Y, 4);  add(56, 1, S_VO, 0);
        add(70, 1, S_Y, 5);  add(70, 1, S_VS, 1);
        add(84, 1, S_Y, 6);  add(84, 1, S_VS, 0);
        add(97, 1, S_X, 13); add(97, 1, S_Y, 6);  add(97, 1, S_LE, 1);
        add(97, 1, S_FE, 1);
        add(98, 1, S_X, 0);  add(98, 1, S_Y, 0);  add(98, 1, S_VO, 1);
        add(98, 1, S_FE, 0);
        add(108, 1, S_HS, 1);
        add(194, 1, S_FE, 0);
        add(195, 1, S_FE, 1);
        add(2559, 0, S_X, 639); add(2559, 0, S_VO, 1);
        add(2560, 0, S_X, 640); add(2560, 0, S_VO, 0);
        add(2623, 0, S_X, 655); add(2623, 0, S_HS, 1);
        add(2624, 0, S_X, 656); add(2624, 0, S_HS, 0);
        add(3007, 0, S_X, 751); add(3007, 0, S_HS, 0);
        add(3008, 0, S_X, 752); add(3008, 0, S_HS, 1);
        add(3199, 0, S_X, 799); add(3199, 0, S_PT, 1);
        add(3199, 0, S_LE, 1);  add(3199, 0, S_FE, 0);
        add(3200, 0, S_X, 0);   add(3200, 0, S_Y, 1);
        add(3200, 0, S_VO, 1);  add(3200, 0, S_LE, 0);
        add(6398, 0, S_LE, 0);
        add(6399, 0, S_LE, 1);
        add(6400, 0, S_Y, 2);   add(6400, 0, S_X, 0);

        // table pass from a clean start
        reset_and_start();
        foreach (vecs[i]) begin
            advance(vecs[i].n);
            check("table", vecs[i].inst, vecs[i].sig, vecs[i].exp);
        end

        // enable dropped mid-line, held low 5 clks, then restarted
        reset_and_start();
        advance(1200);
        check("pre_drop_x", 0, S_X, 300);
        check("pre_drop_vo", 0, S_VO, 1);
        check("pre_drop_small_hs", 1, S_HS, 1);
        enable = 1'b0;
        #1;
        check("drop_pt_comb", 0, S_PT, 0);
        tick();
        check("drop_x", 0, S_X, 0);
        check("drop_y", 0, S_Y, 0);
        check("drop_vo", 0, S_VO, 0);
        check("drop_hs", 0, S_HS, 1);
        check("drop_small_hs", 1, S_HS, 0);
        check("drop_small_y", 1, S_Y, 0);
        repeat (4) tick();
        check("hold_x", 0, S_X, 0);
        check("hold_pt", 0, S_PT, 0);
        enable = 1'b1;
        cur_n  = 0;
        #1;
        check("reen_vo0", 0, S_VO, 0);
        check("reen_small_pt", 1, S_PT, 1);
        advance(1);
        check("reen_vo1", 0, S_VO, 1);
        check("reen_x0", 0, S_X, 0);
        advance(2);
        check("reen_pt_early", 0, S_PT, 0);
        advance(3);
        check("reen_pt", 0, S_PT, 1);
        advance(4);
        check("reen_x1", 0, S_X, 1);

        // asynchronous reset while hsync is active
        reset_and_start();
        advance(2800);
        check("pre_rst_x", 0, S_X, 700);
        check("pre_rst_hs", 0, S_HS, 0);
        check("pre_rst_small_y", 1, S_Y, 4);
        reset = 1'b1;
        #1;
        check("async_rst_hs", 0, S_HS, 1);
        check("async_rst_x", 0, S_X, 0);
        check("async_rst_small_y", 1, S_Y, 0);
        repeat (2) @(posedge clk);
        #2;
        check("held_rst_hs", 0, S_HS, 1);
        reset = 1'b0;
        cur_n = 0;
        #1;
        check("post_rst_pt0", 0, S_PT, 0);
        advance(3);
        check("post_rst_pt", 0, S_PT, 1);
        advance(4);
        check("post_rst_x1", 0, S_X, 1);
        advance(2624);
        check("post_rst_hs", 0, S_HS, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed 640x480, divide-by-4 sync block. It divides the system clock into a pixel-enable tick and runs horizontal and vertical counters with per-field porch, sync and polarity parameters. It drives registered sync, blanking and coordinate outputs to the pixel renderer and the VGA pins, plus line/frame boundary strobes. A synchronous enable gives a soft restart without asserting the global reset.

## Interface
- CLK_DIV, 4: clk cycles per pixel; must be >= 1.
- H_DISPLAY, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal segment lengths in pixels. Each must be >= 1.
- V_DISPLAY, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical segment lengths in lines. Each must be >= 1.
- HS_POL, 0; VS_POL, 0: sync active level (0 = active-low).
- CW, 10: coordinate width. Must satisfy 2^CW > max(H_TOTAL, V_TOTAL) - 1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  0 = hold in the blanked start state; 1 = run.
- p_tick  out  1  one-clk pixel-enable pulse.
- hsync  out  1  horizontal sync, polarity per HS_POL.
- vsync  out  1  vertical sync, polarity per VS_POL.
- video_on  out  1  1 while the current (x,y) is in the display area.
- pixel_x  out  CW  horizontal count, 0..H_TOTAL-1.
- pixel_y  out  CW  vertical count, 0..V_TOTAL-1.
- line_end  out  1  one-clk pulse on the tick at the last pixel of each line.
- frame_end  out  1  one-clk pulse on the tick at the last pixel of each frame.

## Operation
- Derived totals: H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK. V_TOTAL is formed the same way from the V_ parameters.
- Segment order on both axes: display, front porch, sync, back porch.
- hsync is active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; defaults give 656..751.
- vsync is active for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]; defaults give 490..491.
- video_on = enable_state AND x < H_DISPLAY AND y < V_DISPLAY.
- Prescaler: div counter 0..CLK_DIV-1, counting only while enable=1.
  - p_tick = enable AND (div == CLK_DIV-1).
  - With CLK_DIV=1, p_tick = enable.
- On a clk edge with p_tick=1:
  - x wraps to 0 at H_TOTAL-1; otherwise x increments.
  - y changes only when x wraps: it wraps to 0 at V_TOTAL-1, otherwise increments.
- line_end = p_tick AND x == H_TOTAL-1.
- frame_end = line_end AND y == V_TOTAL-1.
- enable=0, sampled on a clk edge: div, x and y load 0; hsync and vsync go inactive; video_on goes 0. This state is identical to reset.
- enable 0->1: counting resumes from div=0, (0,0). No partial frame is emitted before (0,0).
- Coordinate arithmetic is unsigned CW-bit. Counters never exceed TOTAL-1, so there is no overflow.

## Timing
- Reset values (asynchronous): div=0, pixel_x=0, pixel_y=0, hsync=~HS_POL, vsync=~VS_POL, video_on=0. p_tick, line_end and frame_end are 0, because they decode from the reset div and counts.
- hsync, vsync and video_on are registered, loaded each clk from the decode of next-state x/y. They therefore change on the same edge as pixel_x/pixel_y, with zero skew: every cycle, these outputs describe the current pixel_x/pixel_y.
- The first edge with enable=1 after reset loads video_on=1 for (0,0) at that edge.
- Coordinates advance exactly once per p_tick. Each pixel is held for CLK_DIV clks.
- The line_end/frame_end pulse is coincident with p_tick. The counters show the wrapped value from the following cycle.
- Reset mid-frame: all registers return to reset values immediately (asynchronous). The bench must see no glitch on the sync outputs beyond the transition to the inactive level.
- enable dropping mid-line: takes effect at the next clk edge, regardless of p_tick.

## Test plan
- Defaults, reset released, enable=1: first p_tick 4 clks after release. frame_end period = 800*525*4 = 1,680,000 clk. line_end period = 3200 clk.
- Defaults, per-line check: hsync=0 exactly for x 656..751 (96 ticks). video_on=1 for x 0..639 and y 0..479 only. vsync=0 only for y 490..491.
- CLK_DIV=1, H=8/2/2/2, V=4/1/1/1, HS_POL=VS_POL=1: p_tick constant 1. hsync=1 at x 10..11. vsync=1 at y 5. frame = 14*7 = 98 clk.
- enable pulled low at x=300, y=100 for 5 clk, then high: x=y=0, video_on=0, syncs inactive on the next edge. Restart at (0,0), with first p_tick CLK_DIV clks after re-enable.
- reset asserted while hsync is active (x=700): hsync goes inactive and counts go to 0 asynchronously. After release, the timing matches the post-reset scenario.
- Wrap boundary: at x=799, y=524 with p_tick, line_end=frame_end=1. Next cycle pixel_x=0, pixel_y=0, video_on=1.
